// File: rtl/dec_2_4_dat_pkg.sv
// Shared constants and the 2-to-4 decode function for dec_2_4_dat.
package dec_2_4_dat_pkg;

    localparam int ADDR_W    = 2;
    localparam int N_OUT     = 4;
    localparam int CNT_W_DEF = 8;

    // Returns the single active line for addr, or all zeros when disabled.
    function automatic logic [N_OUT-1:0] decode2to4(input logic en, input logic [ADDR_W-1:0] addr);
        logic [N_OUT-1:0] res;
        res = '0;
        if (en) begin
            res[addr] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_hit_counter.sv
// One saturating hit counter: counts cycles with inc high, clr has priority.
module dec_hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dec_2_4_dat.sv
// 2-to-4 decoder with optional output register (OUT_REG) and one-hot checker.
// Defining DEC_HIT_CNT_EN adds four per-line saturating hit counters.
module dec_2_4_dat
    import dec_2_4_dat_pkg::*;
#(
    parameter int OUT_REG = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             a1,
    input  logic             a0,
    output logic             d3,
    output logic             d2,
    output logic             d1,
    output logic             d0,
    output logic             onehot_err
`ifdef DEC_HIT_CNT_EN
    ,
    input  logic             cnt_clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_q
`endif
);

    logic [N_OUT-1:0] dec_next;
    logic [N_OUT-1:0] d;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign dec_next = decode2to4(En, {a1, a0});

    if (OUT_REG != 0) begin : g_out_reg
        logic [N_OUT-1:0] d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
            end else begin
                d_q <= dec_next;
            end
        end

        assign d = d_q;
    end else begin : g_out_comb
        assign d = dec_next;
    end

    assign {d3, d2, d1, d0} = d;

    // Any pair of set bits leaves a bit behind after clearing the lowest one.
    assign onehot_err = |(d & (d - 4'd1));

`ifdef DEC_HIT_CNT_EN
    logic [CNT_W-1:0] cnt [N_OUT];

    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
        dec_hit_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (d[i]),
            .clr  (cnt_clr),
            .q    (cnt[i])
        );
    end

    assign cnt_q = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_dec_2_4_dat.sv
// Directed bench for dec_2_4_dat: registered and combinational instances side by side.
module tb_dec_2_4_dat;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a1;
    logic       a0;
    logic [3:0] d_reg;
    logic       err_reg;
    logic [3:0] d_comb;
    logic       err_comb;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] exp_q[$];

`ifdef DEC_HIT_CNT_EN
    logic       cnt_clr;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_q;
    logic [7:0] cnt_q_comb;
`endif

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dec_2_4_dat #(
        .OUT_REG(1),
        .CNT_W  (8)
    ) u_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (en),
        .a1        (a1),
        .a0        (a0),
        .d3        (d_reg[3]),
        .d2        (d_reg[2]),
        .d1        (d_reg[1]),
        .d0        (d_reg[0]),
        .onehot_err(err_reg)
`ifdef DEC_HIT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt_sel   (cnt_sel),
        .cnt_q     (cnt_q)
`endif
    );

    dec_2_4_dat #(
        .OUT_REG(0),
        .CNT_W  (8)
    ) u_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (en),
        .a1        (a1),
        .a0        (a0),
        .d3        (d_comb[3]),
        .d2        (d_comb[2]),
        .d1        (d_comb[1]),
        .d0        (d_comb[0]),
        .onehot_err(err_comb)
`ifdef DEC_HIT_CNT_EN
        ,
        .cnt_clr   (1'b0),
        .cnt_sel   (2'b00),
        .cnt_q     (cnt_q_comb)
`endif
    );

    // Driver tasks
    task automatic set_in(input logic e, input logic [1:0] a);
        en = e;
        {a1, a0} = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       en;
        logic [1:0] a;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [4:0] exp_reg;
        logic [4:0] shown;

        vecs[0]  = '{1'b0, 2'b00, 4'b0000};
        vecs[1]  = '{1'b0, 2'b01, 4'b0000};
        vecs[2]  = '{1'b0, 2'b10, 4'b0000};
        vecs[3]  = '{1'b0, 2'b11, 4'b0000};
        vecs[4]  = '{1'b1, 2'b00, 4'b0001};
        vecs[5]  = '{1'b1, 2'b01, 4'b0010};
        vecs[6]  = '{1'b1, 2'b10, 4'b0100};
        vecs[7]  = '{1'b1, 2'b11, 4'b1000};
        vecs[8]  = '{1'b0, 2'b11, 4'b0000};
        vecs[9]  = '{1'b1, 2'b10, 4'b0100};
        vecs[10] = '{1'b1, 2'b01, 4'b0010};
        vecs[11] = '{1'b0, 2'b01, 4'b0000};

        rst_n = 1'b0;
        set_in(1'b1, 2'b11);
`ifdef DEC_HIT_CNT_EN
        cnt_clr = 1'b0;
        cnt_sel = 2'b00;
`endif
        #1;
        check("reset_d_err", {d_reg, err_reg}, 5'b00000);
        tick();
        tick();
        check("reset_held_d_err", {d_reg, err_reg}, 5'b00000);
`ifdef DEC_HIT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            check($sformatf("reset_cnt%0d", i), 32'(cnt_q), 32'd0);
        end
`endif
        set_in(1'b0, 2'b00);
        rst_n = 1'b1;
        tick();
        shown = 5'b00000;

        // Table: combinational instance checked at once, registered one a cycle later.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].en, vecs[i].a);
            #1;
            check($sformatf("comb_vec%0d", i), {d_comb, err_comb}, {vecs[i].exp_d, 1'b0});
            check($sformatf("reg_hold_vec%0d", i), {d_reg, err_reg}, shown);
            exp_q.push_back({vecs[i].exp_d, 1'b0});
            tick();
            exp_reg = exp_q.pop_front();
            check($sformatf("reg_vec%0d", i), {d_reg, err_reg}, exp_reg);
            shown = exp_reg;
        end

        // En falling on the combinational instance clears d2 without a clock edge.
        set_in(1'b1, 2'b10);
        #1;
        check("comb_en_high_d2", 32'(d_comb), 32'b0100);
        en = 1'b0;
        #1;
        check("comb_en_fall_d2", 32'(d_comb), 32'b0000);
        tick();
        check("reg_en_fall_d", 32'(d_reg), 32'b0000);

        // Asynchronous reset in mid-cycle, held across an edge, then released.
        set_in(1'b1, 2'b11);
        tick();
        check("pre_reset_d3", {d_reg, err_reg}, 5'b10000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_d", {d_reg, err_reg}, 5'b00000);
        tick();
        check("reset_over_edge_d", {d_reg, err_reg}, 5'b00000);
        rst_n = 1'b1;
        #2;
        check("post_release_no_edge_d", {d_reg, err_reg}, 5'b00000);
        tick();
        check("first_decode_after_release", {d_reg, err_reg}, 5'b10000);

`ifdef DEC_HIT_CNT_EN
        // Clear, then count d0 hits: registered d0 goes high at the first edge, counted from the second.
        set_in(1'b0, 2'b00);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        cnt_sel = 2'b11;
        #1;
        check("cnt3_after_clr", 32'(cnt_q), 32'd0);
        set_in(1'b1, 2'b00);
        tick();
        tick();
        tick();
        cnt_sel = 2'b00;
        #1;
        check("cnt0_two_hits", 32'(cnt_q), 32'd2);
        // Clear on the same edge as a d0 hit.
        set_in(1'b0, 2'b00);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        check("cnt0_clr_beats_hit", 32'(cnt_q), 32'd0);
        tick();
        check("cnt0_clr_stays", 32'(cnt_q), 32'd0);

        // Saturation on line 1.
        set_in(1'b1, 2'b01);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        cnt_sel = 2'b01;
        #1;
        check("cnt1_saturated", 32'(cnt_q), 32'd255);
        cnt_sel = 2'b00;
        #1;
        check("cnt0_idle", 32'(cnt_q), 32'd0);
        cnt_sel = 2'b10;
        #1;
        check("cnt2_idle", 32'(cnt_q), 32'd0);
`endif

        check("final_err_reg", 32'(err_reg), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dec_2_4_dat.md
DEC_2_4_DAT -- requirements
Module: dec_2_4_dat

Interface
REQ-001 Parameter OUT_REG, default 1: 1 = registered outputs (1-cycle latency); 0 = combinational outputs, clock/reset unused.
REQ-002 Parameter CNT_W, default 8: hit-counter width, used only when DEC_HIT_CNT_EN is defined.
REQ-003 Port clk  input  1  single clock, rising-edge active.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port En  input  1  decoder enable, active-high.
REQ-006 Port a1  input  1  address MSB.
REQ-007 Port a0  input  1  address LSB.
REQ-008 Ports d3, d2, d1, d0  output  1 each  decoded lines, active-high.
REQ-009 Port onehot_err  output  1  high when {d3,d2,d1,d0} is neither all-zero nor one-hot; 0 in a correct design.
REQ-010 Ports present only with DEC_HIT_CNT_EN: cnt_clr input 1 (synchronous clear of all counters); cnt_sel input 2 (counter select); cnt_q output CNT_W (selected counter value).

Function
REQ-011 Decode rule: En=1 -> d[{a1,a0}]=1 and other lines 0; En=0 -> all four lines 0.
REQ-012 Truth table with En=1: 00->d0, 01->d1, 10->d2, 11->d3.
REQ-013 OUT_REG=1: outputs show the decode of En/a1/a0 sampled at the previous rising clk edge; exactly 1-cycle latency.
REQ-014 OUT_REG=0: outputs follow the inputs combinationally; zero latency.
REQ-015 Address changes while En=0 produce no output activity.
REQ-016 When En falls, all outputs are 0 from the next edge (OUT_REG=1) or immediately (OUT_REG=0).
REQ-017 onehot_err is combinational from the output lines.
REQ-018 Counter i increments by 1 on each rising edge where the registered d_i is 1; it saturates at 2^CNT_W-1 and does not wrap.
REQ-019 cnt_clr=1 zeroes all counters on the next edge; if a hit occurs on the same edge, the clear wins.
REQ-020 cnt_q = counter[cnt_sel]; the read path is combinational.

Reset
REQ-021 While rst_n=0, d3..d0 = 0 and onehot_err = 0.
REQ-022 While rst_n=0, all hit counters = 0.
REQ-023 Reset assertion takes effect immediately, including mid-operation; the first decode after release happens at the first rising edge with rst_n=1.

Configuration
REQ-024 Macro DEC_HIT_CNT_EN defined: the four per-line saturating hit counters and the cnt_clr, cnt_sel and cnt_q ports are built.
REQ-025 Macro DEC_HIT_CNT_EN undefined: no counters and no counter ports; decode behaviour is unchanged.

Structure
REQ-026 Package dec_2_4_dat_pkg holds ADDR_W=2, N_OUT=4, the default CNT_W, and a pure function decode2to4(en, addr) returning a 4-bit one-hot-or-zero value.
REQ-027 Sub-module dec_hit_counter provides one saturating counter with inc, clr, async active-low reset, and a CNT_W output; it is instantiated four times under DEC_HIT_CNT_EN.

Verification
REQ-028 En=0, sweep {a1,a0} through 00, 01, 10, 11 -> d3..d0 = 0000 for every step; onehot_err = 0.
REQ-029 En=1, sweep 00, 01, 10, 11 with OUT_REG=1 -> one cycle later d3..d0 = 0001, 0010, 0100, 1000.
REQ-030 En=1, a=11, then assert rst_n=0 between edges -> outputs go to 0000 at once without a clock edge and stay 0 until the first edge after release.
REQ-031 OUT_REG=0, toggle En 1->0 with a=10 -> d2 falls 1->0 in the same timestep.
REQ-032 With DEC_HIT_CNT_EN and CNT_W=8, hold En=1, a=01 for 300 cycles -> cnt_sel=01 reads cnt_q=255; cnt_sel=00 reads 0.
REQ-033 With DEC_HIT_CNT_EN, assert cnt_clr in the same cycle as a hit on d0 -> counter 0 reads 0 on the next cycle.
